palette_lut: RTL

PALETTE_LUT -- requirements
Module: palette_lut

---
 rtl/palette_lut_if.sv | 39 +++
 rtl/palette_lut.sv | 94 +++++++++
 2 files changed

// File: rtl/palette_lut_if.sv
// Palette lookup bus: frame commit, lookup, write and result signals.
// The master drives requests; the slave returns looked-up colours.
interface palette_lut_if #(
  parameter int INDEX_W = 8,
  parameter int CH_W    = 4,
  parameter int BANK_W  = 1
);
  logic                frame_start;
  logic [BANK_W-1:0]   bank_sel;
  logic [1:0]          dim;
  logic                rd_valid;
  logic [INDEX_W-1:0]  rd_index;
  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [INDEX_W-1:0]  wr_index;
  logic [3*CH_W-1:0]   wr_data;
  logic                out_valid;
  logic [CH_W-1:0]     red;
  logic [CH_W-1:0]     green;
  logic [CH_W-1:0]     blue;
  logic                transparent;
  logic [BANK_W-1:0]   active_bank;

  modport master (
    output frame_start, bank_sel, dim,
    output rd_valid, rd_index,
    output wr_en, wr_bank, wr_index, wr_data,
    input  out_valid, red, green, blue,
    input  transparent, active_bank
  );

  modport slave (
    input  frame_start, bank_sel, dim,
    input  rd_valid, rd_index,
    input  wr_en, wr_bank, wr_index, wr_data,
    output out_valid, red, green, blue,
    output transparent, active_bank
  );
endinterface

// File: rtl/palette_lut.sv
// Banked colour palette with 2-cycle lookup, dimming and
// frame-synchronous bank/dim switching.
module palette_lut #(
  parameter int INDEX_W    = 8,
  parameter int CH_W       = 4,
  parameter int BANKS      = 2,
  parameter int TRANSP_IDX = 0,
  localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic         Clk,
  input  logic         Reset,
  palette_lut_if.slave bus
);

  localparam int ADDR_W = (BANKS > 1) ? BANK_W + INDEX_W : INDEX_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DW     = 3 * CH_W;
  localparam logic [INDEX_W-1:0] TIDX = INDEX_W'(TRANSP_IDX);

  logic [DW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;

  logic [BANK_W-1:0] act_bank;
  logic [1:0]        act_dim;

  logic              v1;
  logic              match1;
  logic [1:0]        dim1;
  logic [DW-1:0]     rdata;

  // Single-bank builds address by index alone; bank inputs are ignored
  if (BANKS > 1) begin : g_multi
    assign raddr = {act_bank, bus.rd_index};
    assign waddr = {bus.wr_bank, bus.wr_index};
  end else begin : g_single
    assign raddr = bus.rd_index;
    assign waddr = bus.wr_index;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_bank <= '0;
      act_dim  <= '0;
    end else if (bus.frame_start) begin
      act_bank <= (BANKS > 1) ? bus.bank_sel : '0;
      act_dim  <= bus.dim;
    end
  end

  // Read-before-write falls out of the non-blocking update
  always_ff @(posedge Clk) begin
    if (bus.wr_en && !Reset)
      mem[waddr] <= bus.wr_data;
  end

  always_ff @(posedge Clk) begin
    if (bus.rd_valid)
      rdata <= mem[raddr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1     <= 1'b0;
      match1 <= 1'b0;
      dim1   <= '0;
    end else begin
      v1     <= bus.rd_valid;
      match1 <= (bus.rd_index == TIDX);
      dim1   <= act_dim;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.out_valid   <= 1'b0;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
      bus.transparent <= 1'b0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.red         <= rdata[DW-1 -: CH_W] >> dim1;
        bus.green       <= rdata[2*CH_W-1 -: CH_W] >> dim1;
        bus.blue        <= rdata[CH_W-1:0] >> dim1;
        bus.transparent <= match1;
      end
    end
  end

  assign bus.active_bank = act_bank;

endmodule
